// File: rtl/ql_step_controller.sv
// Episode/step sequencer for the Q-learning datapath: walks select/eval/write/advance
// per step, counts steps and episodes, and decays the exploration threshold.
module ql_step_controller #(
    parameter logic [7:0]  GOAL_STATE   = 8'd99,
    parameter logic [9:0]  MAX_STEPS    = 10'd400,
    parameter logic [15:0] MAX_EPISODES = 16'd1000,
    parameter logic [9:0]  EPS_INIT     = 10'd900,
    parameter logic [9:0]  EPS_MIN      = 10'd50,
    parameter logic [9:0]  EPS_STEP     = 10'd25,
    parameter logic [15:0] DECAY_PERIOD = 16'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    input  logic [9:0]  randomValue,
    input  logic [7:0]  nxtState,
    output logic        stateRst,
    output logic        actSel,
    output logic        wrEn,
    output logic        stateLd,
    output logic        busy,
    output logic        done,
    output logic [9:0]  epsilon,
    output logic [9:0]  stepCount,
    output logic [15:0] episodeCount
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] EP_START = 3'd1;
    localparam logic [2:0] SELECT   = 3'd2;
    localparam logic [2:0] EVAL     = 3'd3;
    localparam logic [2:0] WRITE    = 3'd4;
    localparam logic [2:0] ADVANCE  = 3'd5;
    localparam logic [2:0] EP_END   = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    logic [2:0]  state, state_nx;
    logic        held;
    logic [15:0] decay_cnt, decay_inc;
    logic [9:0]  step_inc;
    logic [15:0] ep_inc;
    logic [9:0]  eps_dec;
    logic        ep_finish;

    assign step_inc  = stepCount + 10'd1;
    assign ep_inc    = episodeCount + 16'd1;
    assign decay_inc = decay_cnt + 16'd1;
    assign ep_finish = (nxtState == GOAL_STATE) || (step_inc == MAX_STEPS);

    // Widen by one bit so EPS_MIN + EPS_STEP cannot wrap before the compare.
    assign eps_dec = ({1'b0, epsilon} >= ({1'b0, EPS_MIN} + {1'b0, EPS_STEP}))
                     ? (epsilon - EPS_STEP) : EPS_MIN;

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = EP_START;
            EP_START:   state_nx = SELECT;
            SELECT:     state_nx = EVAL;
            EVAL:       state_nx = WRITE;
            WRITE:      state_nx = ADVANCE;
            ADVANCE:    state_nx = ep_finish ? EP_END : SELECT;
            EP_END:     state_nx = (ep_inc == MAX_EPISODES) ? DONE : EP_START;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            held         <= 1'b0;
            stateRst     <= 1'b0;
            wrEn         <= 1'b0;
            stateLd      <= 1'b0;
            actSel       <= 1'b0;
            stepCount    <= 10'd0;
            episodeCount <= 16'd0;
            epsilon      <= EPS_INIT;
            decay_cnt    <= 16'd0;
        end else if (hold) begin
            held     <= 1'b1;
            stateRst <= 1'b0;
            wrEn     <= 1'b0;
            stateLd  <= 1'b0;
        end else if (held) begin
            // First cycle after a hold replays the frozen state's strobe once.
            held     <= 1'b0;
            stateRst <= (state == EP_START);
            wrEn     <= (state == WRITE);
            stateLd  <= (state == ADVANCE);
        end else begin
            state    <= state_nx;
            stateRst <= (state_nx == EP_START);
            wrEn     <= (state_nx == WRITE);
            stateLd  <= (state_nx == ADVANCE);
            case (state)
                IDLE, DONE: if (start) begin
                    episodeCount <= 16'd0;
                    epsilon      <= EPS_INIT;
                    decay_cnt    <= 16'd0;
                end
                SELECT:  actSel    <= (randomValue < epsilon);
                ADVANCE: stepCount <= step_inc;
                EP_END: begin
                    episodeCount <= ep_inc;
                    if (decay_inc == DECAY_PERIOD) begin
                        decay_cnt <= 16'd0;
                        epsilon   <= eps_dec;
                    end else begin
                        decay_cnt <= decay_inc;
                    end
                end
                default: ;
            endcase
            if (state_nx == EP_START) stepCount <= 10'd0;
        end
    end

endmodule
